// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and the multi-cycle MULT/DIV unit. Writeback always has priority.
// MULT/DIV results queue in a small FIFO until the port is free. A per-register
// scoreboard marks the destinations of outstanding MULT/DIV operations so that
// decode stalls instead of reading or overwriting them early.
//
// Optional feature macro: RF_ARB_BYPASS_EN
//   When defined, a MULT/DIV result that arrives while the FIFO is empty and
//   writeback is idle is written straight through in the same cycle.
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), async active-low reset
//   i_wb_we/addr/data           pipeline writeback request (no backpressure)
//   i_md_valid/addr/data        MULT/DIV result, handshake with o_md_ready
//   o_md_ready                  FIFO not full
//   i_md_issue/issue_addr       MULT/DIV op issued, marks destination busy
//   i_chk_regA/regB/regW        decode registers checked against scoreboard
//   o_stall                     any checked register is busy
//   o_rf_we/regW/busW           register file write port
//   o_err                       sticky: issue to an already-busy register
module rf_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_md_valid,
    output logic              o_md_ready,
    input  logic [ADDR_W-1:0] i_md_addr,
    input  logic [DATA_W-1:0] i_md_data,
    input  logic              i_md_issue,
    input  logic [ADDR_W-1:0] i_md_issue_addr,
    input  logic [ADDR_W-1:0] i_chk_regA,
    input  logic [ADDR_W-1:0] i_chk_regB,
    input  logic [ADDR_W-1:0] i_chk_regW,
    output logic              o_stall,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_regW,
    output logic [DATA_W-1:0] o_rf_busW,
    output logic              o_err
);

    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                bypass;
    logic                commit;
    logic [ADDR_W-1:0]   commit_addr;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                err;
    logic                err_set;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // Ready depends only on the stored count, so a pop in a full cycle does
    // not open a slot until the next cycle.
    assign o_md_ready = !fifo_full;

`ifdef RF_ARB_BYPASS_EN
    assign bypass = i_md_valid && fifo_empty && !i_wb_we;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result goes straight to the port and never occupies a slot.
    assign push = i_md_valid && !fifo_full && !bypass;
    assign pop  = !i_wb_we && !fifo_empty;

    // Write-port mux: writeback, then FIFO head, then (optionally) bypass.
    // Register 0 is never written, but the source is still consumed.
    always_comb begin
        o_rf_we   = 1'b0;
        o_rf_regW = '0;
        o_rf_busW = '0;
        if (i_wb_we) begin
            o_rf_we   = (i_wb_addr != '0);
            o_rf_regW = i_wb_addr;
            o_rf_busW = i_wb_data;
        end else if (!fifo_empty) begin
            o_rf_we   = (fifo_addr[rd_ptr] != '0);
            o_rf_regW = fifo_addr[rd_ptr];
            o_rf_busW = fifo_data[rd_ptr];
        end else if (bypass) begin
            o_rf_we   = (i_md_addr != '0);
            o_rf_regW = i_md_addr;
            o_rf_busW = i_md_data;
        end
    end

    assign commit      = pop || bypass;
    assign commit_addr = pop ? fifo_addr[rd_ptr] : i_md_addr;

    // Clear of a committing destination is applied before the set of a new
    // issue, so re-issuing to a register completing this cycle stays busy.
    always_comb begin
        busy_next = busy;
        if (commit) begin
            busy_next[commit_addr] = 1'b0;
        end
        if (i_md_issue) begin
            busy_next[i_md_issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign err_set = i_md_issue && (i_md_issue_addr != '0) && busy[i_md_issue_addr]
                     && !(commit && (commit_addr == i_md_issue_addr));

    assign o_stall = busy[i_chk_regA] | busy[i_chk_regB] | busy[i_chk_regW];
    assign o_err   = err;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_md_addr;
            fifo_data[wr_ptr] <= i_md_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy <= busy_next;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter
// Directed bench for rf_wr_arbiter (default FIFO_DEPTH=2). A table of
// per-cycle vectors covers writeback pass-through, WB/MULT-DIV collisions,
// full-FIFO behaviour, register-0 drops, the scoreboard clear/set ordering
// and the sticky error. Hand-written sequences cover reset, the r8
// issue/complete timing and an asynchronous reset in mid-operation.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic [4:0]  chk_w;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_regw;
    logic [31:0] rf_busw;
    logic        err;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        int          wb_we;
        int          wb_addr;
        logic [31:0] wb_data;
        int          md_valid;
        int          md_addr;
        logic [31:0] md_data;
        int          issue;
        int          issue_addr;
        int          chk_a;
        int          chk_b;
        int          chk_w;
        int          e_we;
        int          e_regw;
        logic [31:0] e_busw;
        int          e_ready;
        int          e_stall;
        int          e_err;
    } vec_t;

    vec_t vecs[$];

    rf_wr_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .FIFO_DEPTH(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wb_we(wb_we),
        .i_wb_addr(wb_addr),
        .i_wb_data(wb_data),
        .i_md_valid(md_valid),
        .o_md_ready(md_ready),
        .i_md_addr(md_addr),
        .i_md_data(md_data),
        .i_md_issue(md_issue),
        .i_md_issue_addr(md_issue_addr),
        .i_chk_regA(chk_a),
        .i_chk_regB(chk_b),
        .i_chk_regW(chk_w),
        .o_stall(stall),
        .o_rf_we(rf_we),
        .o_rf_regW(rf_regw),
        .o_rf_busW(rf_busw),
        .o_err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input int w_we, input int w_addr, input logic [31:0] w_data,
                                 input int m_valid, input int m_addr, input logic [31:0] m_data,
                                 input int iss, input int iss_addr,
                                 input int ca, input int cb, input int cw);
        wb_we         = (w_we != 0);
        wb_addr       = 5'(w_addr);
        wb_data       = w_data;
        md_valid      = (m_valid != 0);
        md_addr       = 5'(m_addr);
        md_data       = m_data;
        md_issue      = (iss != 0);
        md_issue_addr = 5'(iss_addr);
        chk_a         = 5'(ca);
        chk_b         = 5'(cb);
        chk_w         = 5'(cw);
    endtask

    // Address/data are only compared when a write is expected.
    task automatic checkOutput(input string name, input int e_we, input int e_regw,
                               input logic [31:0] e_busw, input int e_ready,
                               input int e_stall, input int e_err);
        logic ok;
        ok = (rf_we === (e_we != 0)) && (md_ready === (e_ready != 0))
             && (stall === (e_stall != 0)) && (err === (e_err != 0));
        if (e_we != 0) begin
            ok = ok && (rf_regw === 5'(e_regw)) && (rf_busw === e_busw);
        end
        vec_count++;
        if (!ok) begin
            miss_count++;
            $display("[TB] FAIL %s: got we=%b regW=%0d busW=%h ready=%b stall=%b err=%b, expected we=%0d regW=%0d busW=%h ready=%0d stall=%0d err=%0d",
                     name, rf_we, rf_regw, rf_busw, md_ready, stall, err,
                     e_we, e_regw, e_busw, e_ready, e_stall, e_err);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input int w_we, input int w_addr, input logic [31:0] w_data,
                          input int m_valid, input int m_addr, input logic [31:0] m_data,
                          input int iss, input int iss_addr,
                          input int ca, input int cb, input int cw,
                          input int e_we, input int e_regw, input logic [31:0] e_busw,
                          input int e_ready, input int e_stall, input int e_err);
        vec_t v;
        v.wb_we = w_we;   v.wb_addr = w_addr;   v.wb_data = w_data;
        v.md_valid = m_valid; v.md_addr = m_addr; v.md_data = m_data;
        v.issue = iss;    v.issue_addr = iss_addr;
        v.chk_a = ca;     v.chk_b = cb;         v.chk_w = cw;
        v.e_we = e_we;    v.e_regw = e_regw;    v.e_busw = e_busw;
        v.e_ready = e_ready; v.e_stall = e_stall; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    initial begin
        // One entry per clock cycle; state carries across entries.
        //      wb: we addr data        md: valid addr data    issue  chk a b w  exp: we regW busW ready stall err
        // idle and plain writeback
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        addVec(1, 3, 32'hDEADBEEF,   0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 3,  32'hDEADBEEF,   1, 0, 0);
        addVec(1, 0, 32'h5,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        // collision: r2 x3 from WB, r5/r6 queued behind
        addVec(1, 2, 32'hA1,         1, 5,  32'h55,  0, 0,  0, 0, 0,  1, 2,  32'hA1,         1, 0, 0);
        addVec(1, 2, 32'hA2,         1, 6,  32'h66,  0, 0,  0, 0, 0,  1, 2,  32'hA2,         1, 0, 0);
        addVec(1, 2, 32'hA3,         0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 2,  32'hA3,         0, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 5,  32'h55,         0, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 6,  32'h66,         1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        // full FIFO: producer holds r12 while full, then push+pop keeps count at 1
        addVec(1, 1, 32'hB1,         1, 10, 32'hA,   0, 0,  0, 0, 0,  1, 1,  32'hB1,         1, 0, 0);
        addVec(1, 1, 32'hB2,         1, 11, 32'hB,   0, 0,  0, 0, 0,  1, 1,  32'hB2,         1, 0, 0);
        addVec(0, 0, 32'h0,          1, 12, 32'hC,   0, 0,  0, 0, 0,  1, 10, 32'hA,          0, 0, 0);
        addVec(0, 0, 32'h0,          1, 12, 32'hC,   0, 0,  0, 0, 0,  1, 11, 32'hB,          1, 0, 0);
        addVec(0, 0, 32'h0,          1, 13, 32'hD,   0, 0,  0, 0, 0,  1, 12, 32'hC,          1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 13, 32'hD,          1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        // MD result to r0 is dropped but still consumed
        addVec(1, 4, 32'hC,          1, 0,  32'h99,  0, 0,  0, 0, 0,  1, 4,  32'hC,          1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        addVec(1, 4, 32'h44,         1, 7,  32'h77,  0, 0,  0, 0, 0,  1, 4,  32'h44,         1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  1, 7,  32'h77,         1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        // re-issue r15 in the cycle its result commits: stays busy, no error
        addVec(1, 1, 32'h0,          1, 15, 32'hF,   1, 15, 0, 0, 0,  1, 1,  32'h0,          1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   1, 15, 15,0, 0,  1, 15, 32'hF,          1, 1, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  15,0, 0,  0, 0,  32'h0,          1, 1, 0);
        addVec(1, 1, 32'h0,          1, 15, 32'hF2,  0, 0,  15,0, 0,  1, 1,  32'h0,          1, 1, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  15,0, 0,  1, 15, 32'hF2,         1, 1, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  15,0, 0,  0, 0,  32'h0,          1, 0, 0);
        // double issue to r9 sets the sticky error
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   1, 9,  9, 0, 0,  0, 0,  32'h0,          1, 0, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   1, 9,  9, 0, 0,  0, 0,  32'h0,          1, 1, 0);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  9, 0, 0,  0, 0,  32'h0,          1, 1, 1);
        addVec(0, 0, 32'h0,          0, 0,  32'h0,   0, 0,  0, 0, 0,  0, 0,  32'h0,          1, 0, 1);

        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("reset_idle", 0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        rst_n = 1'b1;

        // r8: issue, then result accepted, written, and busy released
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 1, 8, 8, 0, 0);
        #4;
        checkOutput("r8_issue", 0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 1, 8, 32'h1234, 0, 0, 0, 8, 0);
        #4;
`ifdef RF_ARB_BYPASS_EN
        checkOutput("r8_accept", 1, 8, 32'h1234, 1, 1, 0);
        nextCycle();
`else
        checkOutput("r8_accept", 0, 0, 32'h0, 1, 1, 0);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 8);
        #4;
        checkOutput("r8_write", 1, 8, 32'h1234, 1, 1, 0);
        nextCycle();
`endif
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 8, 8, 8);
        #4;
        checkOutput("r8_released", 0, 0, 32'h0, 1, 0, 0);
        nextCycle();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data,
                          vecs[i].md_valid, vecs[i].md_addr, vecs[i].md_data,
                          vecs[i].issue, vecs[i].issue_addr,
                          vecs[i].chk_a, vecs[i].chk_b, vecs[i].chk_w);
            #4;
            checkOutput($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_regw, vecs[i].e_busw,
                        vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_err);
            nextCycle();
        end

        // Mid-operation reset with a buffered result, busy r9 and err set
        applyStimulus(1, 1, 32'h11, 1, 9, 32'h9, 0, 0, 0, 0, 0);
        #4;
        checkOutput("pre_reset_push", 1, 1, 32'h11, 1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 9, 0, 0);
        #4;
        checkOutput("pre_reset_head", 1, 9, 32'h9, 1, 1, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        rst_n = 1'b1;
        #4;
        checkOutput("post_reset", 0, 0, 32'h0, 1, 0, 0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
